// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the bit-period divisor (used by uart_tx too).
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StParity   = 3'd3,
    StStop     = 3'd4,
    StWaitHigh = 3'd5
  } uart_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned uart_divisor(input int unsigned clock_hz,
                                               input int unsigned baud);
    return (clock_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input.
module uart_sync #(
  parameter logic ResetValue = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{ResetValue}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, valid/ready output with overrun detection.
// Define UART_RX_PARITY_EN to add one even-parity bit per frame (8E1); default is 8N1.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned Clock = 50000000,
  parameter int unsigned Baud  = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int unsigned BitClocks  = uart_divisor(Clock, Baud);
  localparam int unsigned HalfClocks = BitClocks / 2;
  localparam int unsigned TimerW     = $clog2(BitClocks + 1);
  localparam logic [TimerW-1:0] TimerBit  = TimerW'(BitClocks);
  localparam logic [TimerW-1:0] TimerHalf = TimerW'(HalfClocks);

`ifdef UART_RX_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  logic              rx_s;
  uart_state_e       state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              done_q, done_d;
  logic              par_bad_q, par_bad_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic [7:0]        data_q;
  logic              valid_q, overrun_q;
  logic              tick;

  uart_sync #(
    .ResetValue(1'b1)
  ) u_sync (
    .clk_i (clock),
    .rst_ni(reset),
    .d_i   (rxd),
    .q_o   (rx_s)
  );

  // Timer counts down and expires on 1, so a load of N samples exactly N clocks later.
  assign tick = (timer_q == TimerW'(1));

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    done_d       = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    if (state_q != StIdle && state_q != StWaitHigh && !tick) begin
      timer_d = timer_q - 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d   = StStart;
          timer_d   = TimerHalf;
          bit_cnt_d = 3'd0;
          par_bad_d = 1'b0;
        end
      end
      StStart: begin
        if (tick) begin
          timer_d = TimerBit;
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (tick) begin
          shift_d   = {rx_s, shift_q[7:1]};
          timer_d   = TimerBit;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ParityEn ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (tick) begin
          timer_d = TimerBit;
          state_d = StStop;
          if ((^shift_q) ^ rx_s) begin
            parity_err_d = 1'b1;
            par_bad_d    = 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (rx_s) begin
            state_d = StIdle;
            done_d  = !par_bad_q;
          end else begin
            state_d     = StWaitHigh;
            frame_err_d = 1'b1;
          end
        end
      end
      StWaitHigh: begin
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      done_q       <= 1'b0;
      par_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      done_q       <= done_d;
      par_bad_q    <= par_bad_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  // A completed byte only replaces data when the previous one is gone or consumed this cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= done_q && valid_q && !ready;
      if (done_q && (!valid_q || ready)) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign parity_err = ParityEn & parity_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 50 MHz / 115200 baud; honours UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int BitT  = 434;
  localparam int HalfT = 217;
`ifdef UART_RX_PARITY_EN
  localparam int ParExtra = BitT;
`else
  localparam int ParExtra = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rxd   = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, overrun, parity_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_rise = 0, n_valid_hi = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
  int rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  logic valid_prev = 1'b0;

  uart_rx #(
    .Clock(50000000),
    .Baud (115200)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (valid && !valid_prev) begin
      n_rise++;
      rise_cyc  = cyc;
      rise_data = data;
    end
    if (valid) n_valid_hi++;
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (parity_err) n_perr++;
    valid_prev = valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BitT) @(negedge clock);
  endtask

  // Call on a negedge; leaves the line idle high.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par) rxd = 1'b1;
`endif
    drive_bit(stop);
    rxd = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * BitT) @(negedge clock);
  endtask

  int t_start, b_rise, b_hi, b_ferr, b_ovr, b_perr;

  task automatic snap();
    b_rise = n_rise;
    b_hi   = n_valid_hi;
    b_ferr = n_ferr;
    b_ovr  = n_ovr;
    b_perr = n_perr;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_eq("rst_data", data, 8'h00);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_ferr", frame_err, 1'b0);
    check_eq("rst_ovr", overrun, 1'b0);
    check_eq("rst_perr", parity_err, 1'b0);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    // 0x55 with ready high: data, exact latency, one-cycle valid
    snap();
    t_start = cyc;
    send_frame(8'h55, 1'b0, 1'b1);
    idle_bits(2);
    check_eq("b55_rises", n_rise - b_rise, 1);
    check_eq("b55_data", rise_data, 8'h55);
    check_eq("b55_latency", rise_cyc - t_start, 4 + HalfT + 9 * BitT + ParExtra);
    check_eq("b55_valid_cycles", n_valid_hi - b_hi, 1);
    check_eq("b55_ferr", n_ferr - b_ferr, 0);

    // 0xA3 with stop bit low, then 0x3C
    snap();
    send_frame(8'hA3, 1'b0, 1'b0);
    idle_bits(2);
    check_eq("ba3_ferr", n_ferr - b_ferr, 1);
    check_eq("ba3_rises", n_rise - b_rise, 0);
    snap();
    send_frame(8'h3C, 1'b0, 1'b1);
    idle_bits(2);
    check_eq("b3c_rises", n_rise - b_rise, 1);
    check_eq("b3c_data", rise_data, 8'h3C);
    check_eq("b3c_ferr", n_ferr - b_ferr, 0);

    // 100-clock glitch
    snap();
    rxd = 1'b0;
    repeat (100) @(negedge clock);
    rxd = 1'b1;
    idle_bits(3);
    check_eq("glitch_rises", n_rise - b_rise, 0);
    check_eq("glitch_ferr", n_ferr - b_ferr, 0);
    check_eq("glitch_ovr", n_ovr - b_ovr, 0);
    check_eq("glitch_perr", n_perr - b_perr, 0);

    // 0x11 then 0x22 back-to-back with ready low
    ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    idle_bits(2);
    check_eq("ovr_data", data, 8'h11);
    check_eq("ovr_valid", valid, 1'b1);
    check_eq("ovr_pulses", n_ovr - b_ovr, 1);
    check_eq("ovr_rises", n_rise - b_rise, 1);
    ready = 1'b1;
    repeat (2) @(negedge clock);
    check_eq("ovr_valid_clr", valid, 1'b0);
    check_eq("ovr_data_kept", data, 8'h11);

    // Reset during bit 4 of 0xF0, then 0x0F
    snap();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rxd = 1'b1;
    repeat (HalfT) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("mid_rst_data", data, 8'h00);
    check_eq("mid_rst_valid", valid, 1'b0);
    check_eq("mid_rst_ferr", frame_err, 1'b0);
    check_eq("mid_rst_ovr", overrun, 1'b0);
    check_eq("mid_rst_perr", parity_err, 1'b0);
    reset = 1'b1;
    idle_bits(6);
    send_frame(8'h0F, 1'b0, 1'b1);
    idle_bits(2);
    check_eq("b0f_rises", n_rise - b_rise, 1);
    check_eq("b0f_data", rise_data, 8'h0F);
    check_eq("b0f_ferr", n_ferr - b_ferr, 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1
    snap();
    send_frame(8'h07, 1'b0, 1'b1);
    idle_bits(2);
    check_eq("par_bad_perr", n_perr - b_perr, 1);
    check_eq("par_bad_rises", n_rise - b_rise, 0);
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(2);
    check_eq("par_ok_rises", n_rise - b_rise, 1);
    check_eq("par_ok_data", rise_data, 8'h07);
    check_eq("par_ok_perr", n_perr - b_perr, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
